// File: rtl/switch_allocator.sv
// Separable input-first round-robin switch allocator (iSLIP pointer update).
// Optional starvation watchdog enabled by defining SWITCH_ALLOC_WATCHDOG_EN.
module switch_allocator #(
  parameter  int unsigned PORT_NUM     = 5,
  parameter  int unsigned VC_NUM       = 2,
  parameter  int unsigned STARVE_LIMIT = 64,
  localparam int unsigned VC_SIZE      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int unsigned PORT_W       = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]               switch_request_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_W-1:0]   out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]  downstream_vc_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]               on_off_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]               read_o,
  output logic [PORT_NUM-1:0][PORT_W-1:0]               xbar_sel_o,
  output logic [PORT_NUM-1:0]                           valid_flit_o,
  output logic                                          err_o,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]               starve_o
);

  logic [PORT_NUM-1:0][VC_SIZE-1:0] in_ptr_q, in_ptr_d;
  logic [PORT_NUM-1:0][PORT_W-1:0]  out_ptr_q, out_ptr_d;
  logic                             err_q, err_d;

  logic [PORT_NUM-1:0][VC_NUM-1:0]  elig;
  logic [PORT_NUM-1:0]              cand_valid;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] cand_vc;
  logic [PORT_NUM-1:0][PORT_W-1:0]  cand_port;
  logic [PORT_NUM-1:0]              in_won;

  // Range checks come before indexing so a bad port never selects an on_off bit.
  always_comb begin
    elig  = '0;
    err_d = 1'b0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        if (switch_request_i[i][v]) begin
          if (32'(out_port_i[i][v]) < PORT_NUM) begin
            if (32'(downstream_vc_i[i][v]) < VC_NUM &&
                on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]])
              elig[i][v] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin : stage1
    int unsigned idx;
    idx        = 0;
    cand_valid = '0;
    cand_vc    = '0;
    cand_port  = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      for (int unsigned k = 0; k < VC_NUM; k++) begin
        idx = (32'(in_ptr_q[i]) + k) % VC_NUM;
        if (!cand_valid[i] && elig[i][idx]) begin
          cand_valid[i] = 1'b1;
          cand_vc[i]    = VC_SIZE'(idx);
          cand_port[i]  = out_port_i[i][idx];
        end
      end
    end
  end

  always_comb begin : stage2
    int unsigned idx;
    idx          = 0;
    valid_flit_o = '0;
    xbar_sel_o   = '0;
    in_won       = '0;
    read_o       = '0;
    out_ptr_d    = out_ptr_q;
    in_ptr_d     = in_ptr_q;
    for (int unsigned o = 0; o < PORT_NUM; o++) begin
      for (int unsigned k = 0; k < PORT_NUM; k++) begin
        idx = (32'(out_ptr_q[o]) + k) % PORT_NUM;
        if (!valid_flit_o[o] && cand_valid[idx] && 32'(cand_port[idx]) == o) begin
          valid_flit_o[o] = 1'b1;
          xbar_sel_o[o]   = PORT_W'(idx);
          in_won[idx]     = 1'b1;
        end
      end
      if (valid_flit_o[o])
        out_ptr_d[o] = PORT_W'((32'(xbar_sel_o[o]) + 1) % PORT_NUM);
    end
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      if (in_won[i]) begin
        read_o[i][cand_vc[i]] = 1'b1;
        in_ptr_d[i]           = VC_SIZE'((32'(cand_vc[i]) + 1) % VC_NUM);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ptr_q  <= '0;
      out_ptr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      in_ptr_q  <= in_ptr_d;
      out_ptr_q <= out_ptr_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;

`ifdef SWITCH_ALLOC_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [PORT_NUM-1:0][VC_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [PORT_NUM-1:0][VC_NUM-1:0]            starve_q, starve_d;

  always_comb begin
    cnt_d    = cnt_q;
    starve_d = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        if (!switch_request_i[i][v] || read_o[i][v])
          cnt_d[i][v] = '0;
        else if (32'(cnt_q[i][v]) < STARVE_LIMIT)
          cnt_d[i][v] = cnt_q[i][v] + CNT_W'(1);
        starve_d[i][v] = (32'(cnt_d[i][v]) >= STARVE_LIMIT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  assign starve_o = starve_q;
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign starve_o = '0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Randomized and directed bench for switch_allocator against a behavioural allocator model.
module tb_switch_allocator;

  localparam int P = 5;
  localparam int V = 2;
  localparam int NORTH = 1, EAST = 2, SOUTH = 3, WEST = 4;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [P-1:0][V-1:0]        req;
  logic [P-1:0][V-1:0][2:0]   oport;
  logic [P-1:0][V-1:0][0:0]   dvc;
  logic [P-1:0][V-1:0]        onoff;
  logic [P-1:0][V-1:0]        read_o;
  logic [P-1:0][2:0]          xsel;
  logic [P-1:0]               vflit;
  logic                       err;
  logic [P-1:0][V-1:0]        starve;

  switch_allocator #(.PORT_NUM(P), .VC_NUM(V), .STARVE_LIMIT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .switch_request_i(req), .out_port_i(oport), .downstream_vc_i(dvc), .on_off_i(onoff),
    .read_o(read_o), .xbar_sel_o(xsel), .valid_flit_o(vflit),
    .err_o(err), .starve_o(starve)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model state: one round-robin pointer per input and per output, kept as plain ints.
  int m_in_ptr[P];
  int m_out_ptr[P];
  int m_win[P];
  int m_gvc[P];
  logic m_bad_now;
  logic exp_err;
  logic [P-1:0][V-1:0] exp_read;
  logic [P-1:0][2:0]   exp_sel;
  logic [P-1:0]        exp_valid;

  task automatic model_reset();
    for (int i = 0; i < P; i++) begin
      m_in_ptr[i]  = 0;
      m_out_ptr[i] = 0;
    end
    exp_err = 1'b0;
  endtask

  task automatic model_eval();
    int cand[P];
    int p, v, i;
    exp_read  = '0;
    exp_sel   = '0;
    exp_valid = '0;
    m_bad_now = 1'b0;
    for (int n = 0; n < P; n++) begin
      cand[n] = -1;
      for (int k = 0; k < V; k++) begin
        v = (m_in_ptr[n] + k) % V;
        p = int'(oport[n][v]);
        if (req[n][v]) begin
          if (p >= P) m_bad_now = 1'b1;
          else if (cand[n] < 0 && onoff[p][dvc[n][v]]) cand[n] = v;
        end
      end
    end
    for (int o = 0; o < P; o++) begin
      m_win[o] = -1;
      for (int k = 0; k < P; k++) begin
        i = (m_out_ptr[o] + k) % P;
        if (m_win[o] < 0 && cand[i] >= 0 && int'(oport[i][cand[i]]) == o) m_win[o] = i;
      end
      if (m_win[o] >= 0) begin
        exp_valid[o] = 1'b1;
        exp_sel[o]   = 3'(m_win[o]);
        exp_read[m_win[o]][cand[m_win[o]]] = 1'b1;
        m_gvc[m_win[o]] = cand[m_win[o]];
      end
    end
  endtask

  task automatic model_commit();
    for (int o = 0; o < P; o++) begin
      if (m_win[o] >= 0) begin
        m_out_ptr[o] = (m_win[o] + 1) % P;
        m_in_ptr[m_win[o]] = (m_gvc[m_win[o]] + 1) % V;
      end
    end
    exp_err = m_bad_now;
  endtask

  task automatic cycle();
    model_eval();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req   = '0;
    oport = '0;
    dvc   = '0;
    onoff = '1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    total++;
    if (read_o !== '0 || vflit !== '0 || xsel !== '0) begin
      bad++; $display("FAIL reset_outputs: got read=%h valid=%h sel=%h want 0", read_o, vflit, xsel);
    end
    total++;
    if (err !== 1'b0 || starve !== '0) begin
      bad++; $display("FAIL reset_flags: got err=%b starve=%h want 0", err, starve);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (read_o !== '0 || vflit !== '0 || err !== 1'b0) begin
        bad++; $display("FAIL idle: got read=%h valid=%h err=%b want 0", read_o, vflit, err);
      end
      cycle();
    end
  endtask

  task automatic test_single();
    do_reset();
    req[1][0] = 1'b1; oport[1][0] = 3'(EAST);
    #1;
    total++;
    if (read_o[1][0] !== 1'b1 || xsel[EAST] !== 3'd1 || vflit[EAST] !== 1'b1) begin
      bad++; $display("FAIL single: got read=%h sel_east=%0d valid=%h want read[1][0] sel=1 valid[EAST]", read_o, xsel[EAST], vflit);
    end
    total++;
    if (vflit !== 5'b00100 || read_o !== 10'b00_00_00_01_00) begin
      bad++; $display("FAIL single_exclusive: got read=%h valid=%h", read_o, vflit);
    end
    cycle();
  endtask

  task automatic test_conflict();
    int seq[4] = '{0, 2, 3, 0};
    do_reset();
    req[0][0] = 1'b1; oport[0][0] = 3'(NORTH);
    req[2][0] = 1'b1; oport[2][0] = 3'(NORTH);
    req[3][0] = 1'b1; oport[3][0] = 3'(NORTH);
    for (int c = 0; c < 4; c++) begin
      #1;
      model_eval();
      total++;
      if (vflit[NORTH] !== 1'b1 || xsel[NORTH] !== 3'(seq[c]) || read_o !== exp_read) begin
        bad++; $display("FAIL conflict[%0d]: got sel=%0d valid=%b read=%h want sel=%0d read=%h", c, xsel[NORTH], vflit[NORTH], read_o, seq[c], exp_read);
      end
      cycle();
    end
  endtask

  task automatic test_vc_fair();
    logic [1:0] seq[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    req[4] = 2'b11; oport[4][0] = 3'(WEST); oport[4][1] = 3'(SOUTH);
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (read_o[4] !== seq[c]) begin
        bad++; $display("FAIL vc_fair[%0d]: got read4=%b want %b", c, read_o[4], seq[c]);
      end
      cycle();
    end
  endtask

  task automatic test_flow_ctrl();
    do_reset();
    onoff[EAST][1] = 1'b0;
    req[0][1] = 1'b1; oport[0][1] = 3'(EAST); dvc[0][1] = 1'b1;
    #1;
    total++;
    if (read_o !== '0 || vflit !== '0) begin
      bad++; $display("FAIL flow_blocked: got read=%h valid=%h want 0", read_o, vflit);
    end
    onoff[EAST][1] = 1'b1;
    #1;
    total++;
    if (read_o[0][1] !== 1'b1 || xsel[EAST] !== 3'd0 || vflit[EAST] !== 1'b1) begin
      bad++; $display("FAIL flow_open: got read=%h sel=%0d valid=%h", read_o, xsel[EAST], vflit);
    end
    cycle();
  endtask

  task automatic test_bad_port();
    do_reset();
    req[1][0] = 1'b1; oport[1][0] = 3'd7;
    #1;
    total++;
    if (read_o !== '0 || vflit !== '0 || err !== 1'b0) begin
      bad++; $display("FAIL bad_port_comb: got read=%h valid=%h err=%b want 0", read_o, vflit, err);
    end
    cycle();
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL bad_port_err: got %b want 1", err);
    end
    clear_inputs();
    cycle();
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL bad_port_pulse: got %b want 0", err);
    end
  endtask

  task automatic randomize_inputs();
    req   = 10'($urandom);
    onoff = 10'($urandom | $urandom);
    for (int i = 0; i < P; i++)
      for (int v = 0; v < V; v++) begin
        oport[i][v] = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        dvc[i][v]   = 1'($urandom);
      end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      randomize_inputs();
      #1;
      model_eval();
      total++;
      if (read_o !== exp_read || xsel !== exp_sel || vflit !== exp_valid) begin
        bad++; $display("FAIL random[%0d]: got read=%h sel=%h valid=%h want read=%h sel=%h valid=%h", c, read_o, xsel, vflit, exp_read, exp_sel, exp_valid);
      end
      cycle();
      total++;
      if (err !== exp_err) begin
        bad++; $display("FAIL random_err[%0d]: got %b want %b", c, err, exp_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 7; c++) begin
      randomize_inputs();
      cycle();
    end
    randomize_inputs();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    model_eval();
    total++;
    if (read_o !== exp_read || xsel !== exp_sel || vflit !== exp_valid || err !== 1'b0) begin
      bad++; $display("FAIL reset_mid: got read=%h sel=%h valid=%h err=%b want read=%h sel=%h valid=%h err=0", read_o, xsel, vflit, err, exp_read, exp_sel, exp_valid);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_idle();
    test_single();
    test_conflict();
    test_vc_fair();
    test_flow_ctrl();
    test_bad_port();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
